// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Purpose : Bundles the fetch->decode handshake, the redirect (flush) and the
//           decode->EX registered outputs into one interface.
// Modports:
//   master : driven by the environment (fetch/EX side). It drives if_valid,
//            if_instr, if_pc, flush and ex_ready. It observes if_ready and all
//            ex_* outputs.
//   slave  : used by decode_stage. Its directions are the mirror image of
//            the master modport.
// Signals : if_valid/if_ready/if_instr[15:0]/if_pc[DATA_W-1:0],
//           flush, ex_ready, ex_valid, ex_alu_src, ex_mem_to_reg,
//           ex_reg_write, ex_mem_write, ex_mem_read, ex_jump,
//           ex_branch[1:0], ex_alu_op[3:0], ex_rd/ex_rs1/ex_rs2[REG_AW-1:0],
//           ex_imm/ex_pc[DATA_W-1:0], ex_illegal
// ---------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) ();
    logic              if_valid;
    logic              if_ready;
    logic [15:0]       if_instr;
    logic [DATA_W-1:0] if_pc;
    logic              flush;
    logic              ex_ready;
    logic              ex_valid;
    logic              ex_alu_src;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;
    logic              ex_mem_write;
    logic              ex_mem_read;
    logic              ex_jump;
    logic [1:0]        ex_branch;
    logic [3:0]        ex_alu_op;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc;
    logic              ex_illegal;

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_ready,
        input  if_ready, ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write,
               ex_mem_write, ex_mem_read, ex_jump, ex_branch, ex_alu_op,
               ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_ready,
        output if_ready, ex_valid, ex_alu_src, ex_mem_to_reg, ex_reg_write,
               ex_mem_write, ex_mem_read, ex_jump, ex_branch, ex_alu_op,
               ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Purpose : MIPS16 decode stage. It decodes the offered instruction
//           combinationally and registers the result toward EX behind a
//           valid/ready handshake. It also tracks the most recent load and
//           inserts load-use bubbles.
// Ports   : clk             - single rising-edge clock
//           rst             - synchronous active-high reset
//           bus (slave)     - fetch handshake, flush, EX handshake and all
//                             registered ex_* decode outputs
// Register index map: R0..R7 = 0..7, SP = 8, T = 9, IH = 10, RA = 11,
//           PC = 12, REG0 (unused / none) = all ones.
// Branch codes: NB = 0, B = 1, BE = 2, BNE = 3.
// ALU codes: none = 0, add = 1, sub = 2, and = 3, or = 4, xor = 5, not = 6,
//           sll = 7, srl = 8, sra = 9, slt = 10, sltu = 11, cmp = 12,
//           neg = 13, pass A = 14, pass B = 15.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int LU_BUBBLES = 1
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [1:0] BR_NB  = 2'd0;
    localparam logic [1:0] BR_B   = 2'd1;
    localparam logic [1:0] BR_BE  = 2'd2;
    localparam logic [1:0] BR_BNE = 2'd3;

    localparam logic [3:0] ALU_NO    = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_NOT   = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_SLT   = 4'd10;
    localparam logic [3:0] ALU_SLTU  = 4'd11;
    localparam logic [3:0] ALU_CMP   = 4'd12;
    localparam logic [3:0] ALU_NEG   = 4'd13;
    localparam logic [3:0] ALU_PASSA = 4'd14;
    localparam logic [3:0] ALU_PASSB = 4'd15;

    localparam logic [REG_AW-1:0] REG_SP = REG_AW'(8);
    localparam logic [REG_AW-1:0] REG_T  = REG_AW'(9);
    localparam logic [REG_AW-1:0] REG_IH = REG_AW'(10);
    localparam logic [REG_AW-1:0] REG_RA = REG_AW'(11);
    localparam logic [REG_AW-1:0] REG_PC = REG_AW'(12);
    localparam logic [REG_AW-1:0] REG0   = {REG_AW{1'b1}};

    // Instruction fields
    logic [4:0]        w_op;
    logic [REG_AW-1:0] w_rx, w_ry, w_rz;
    logic [DATA_W-1:0] w_im3, w_im4, w_im5, w_im8, w_im11, w_imZ8;

    assign w_op   = bus.if_instr[15:11];
    assign w_rx   = REG_AW'(bus.if_instr[10:8]);
    assign w_ry   = REG_AW'(bus.if_instr[7:5]);
    assign w_rz   = REG_AW'(bus.if_instr[4:2]);
    // A shift amount field of 0 encodes a shift by 8
    assign w_im3  = (bus.if_instr[4:2] == 3'd0) ? DATA_W'(8)
                  : {{(DATA_W-3){bus.if_instr[4]}}, bus.if_instr[4:2]};
    assign w_im4  = {{(DATA_W-4){bus.if_instr[3]}}, bus.if_instr[3:0]};
    assign w_im5  = {{(DATA_W-5){bus.if_instr[4]}}, bus.if_instr[4:0]};
    assign w_im8  = {{(DATA_W-8){bus.if_instr[7]}}, bus.if_instr[7:0]};
    assign w_im11 = {{(DATA_W-11){bus.if_instr[10]}}, bus.if_instr[10:0]};
    assign w_imZ8 = {{(DATA_W-8){1'b0}}, bus.if_instr[7:0]};

    // Decoded controls
    logic              w_aluSrc, w_memToReg, w_regWrite, w_memWrite, w_memRead, w_jump;
    logic [1:0]        w_branch;
    logic [3:0]        w_aluOp;
    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_imm;
    logic              w_illegal;

    // Defaults give NOP controls, so any unmatched encoding only has to set
    // w_illegal.
    always_comb begin
        w_aluSrc   = 1'b0;
        w_memToReg = 1'b0;
        w_regWrite = 1'b0;
        w_memWrite = 1'b0;
        w_memRead  = 1'b0;
        w_jump     = 1'b0;
        w_branch   = BR_NB;
        w_aluOp    = ALU_NO;
        w_rd       = REG0;
        w_rs1      = REG0;
        w_rs2      = REG0;
        w_imm      = '0;
        w_illegal  = 1'b0;
        case (w_op)
            5'b00000: begin // ADDSP3
                w_rd = w_rx; w_rs1 = REG_SP; w_imm = w_im8;
                w_aluSrc = 1'b1; w_regWrite = 1'b1; w_aluOp = ALU_ADD;
            end
            5'b00001: begin // NOP
                if (bus.if_instr[10:0] != 11'd0) w_illegal = 1'b1;
            end
            5'b00010: begin // B
                w_branch = BR_B; w_imm = w_im11;
            end
            5'b00100: begin // BEQZ
                w_branch = BR_BE; w_rs1 = w_rx; w_imm = w_im8;
            end
            5'b00101: begin // BNEZ
                w_branch = BR_BNE; w_rs1 = w_rx; w_imm = w_im8;
            end
            5'b00110: begin // SLL / SRL / SRA
                if (bus.if_instr[1:0] == 2'b01) begin
                    w_illegal = 1'b1;
                end else begin
                    w_rd = w_rx; w_rs1 = w_ry; w_imm = w_im3;
                    w_aluSrc = 1'b1; w_regWrite = 1'b1;
                    w_aluOp = (bus.if_instr[1:0] == 2'b00) ? ALU_SLL
                            : (bus.if_instr[1:0] == 2'b10) ? ALU_SRL : ALU_SRA;
                end
            end
            5'b01000: begin // ADDIU3
                if (bus.if_instr[4]) begin
                    w_illegal = 1'b1;
                end else begin
                    w_rd = w_ry; w_rs1 = w_rx; w_imm = w_im4;
                    w_aluSrc = 1'b1; w_regWrite = 1'b1; w_aluOp = ALU_ADD;
                end
            end
            5'b01001: begin // ADDIU
                w_rd = w_rx; w_rs1 = w_rx; w_imm = w_im8;
                w_aluSrc = 1'b1; w_regWrite = 1'b1; w_aluOp = ALU_ADD;
            end
            5'b01010, 5'b01011: begin // SLTI / SLTUI
                w_rd = REG_T; w_rs1 = w_rx; w_imm = w_im8;
                w_aluSrc = 1'b1; w_regWrite = 1'b1;
                w_aluOp = w_op[0] ? ALU_SLTU : ALU_SLT;
            end
            5'b01100: begin
                case (bus.if_instr[10:8])
                    3'b000: begin // BTEQZ
                        w_branch = BR_BE; w_rs1 = REG_T; w_imm = w_im8;
                    end
                    3'b001: begin // BTNEZ
                        w_branch = BR_BNE; w_rs1 = REG_T; w_imm = w_im8;
                    end
                    3'b010: begin // SW_RS
                        w_rs1 = REG_SP; w_rs2 = REG_RA; w_imm = w_im8;
                        w_aluSrc = 1'b1; w_memWrite = 1'b1; w_aluOp = ALU_ADD;
                    end
                    3'b011: begin // ADDSP
                        w_rd = REG_SP; w_rs1 = REG_SP; w_imm = w_im8;
                        w_aluSrc = 1'b1; w_regWrite = 1'b1; w_aluOp = ALU_ADD;
                    end
                    3'b100: begin // MTSP
                        if (bus.if_instr[4:0] != 5'd0) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_rd = REG_SP; w_rs1 = w_ry;
                            w_regWrite = 1'b1; w_aluOp = ALU_PASSA;
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            5'b01101: begin // LI
                w_rd = w_rx; w_imm = w_imZ8;
                w_aluSrc = 1'b1; w_regWrite = 1'b1; w_aluOp = ALU_PASSB;
            end
            5'b01110: begin // CMPI
                w_rd = REG_T; w_rs1 = w_rx; w_imm = w_im8;
                w_aluSrc = 1'b1; w_regWrite = 1'b1; w_aluOp = ALU_CMP;
            end
            5'b01111: begin // MOVE
                if (bus.if_instr[4:0] != 5'd0) begin
                    w_illegal = 1'b1;
                end else begin
                    w_rd = w_rx; w_rs1 = w_ry;
                    w_regWrite = 1'b1; w_aluOp = ALU_PASSA;
                end
            end
            5'b10010, 5'b10011: begin // LW_SP / LW
                w_rd  = w_op[0] ? w_ry : w_rx;
                w_rs1 = w_op[0] ? w_rx : REG_SP;
                w_imm = w_op[0] ? w_im5 : w_im8;
                w_aluSrc = 1'b1; w_memToReg = 1'b1; w_regWrite = 1'b1;
                w_memRead = 1'b1; w_aluOp = ALU_ADD;
            end
            5'b11010, 5'b11011: begin // SW_SP / SW
                w_rs1 = w_op[0] ? w_rx : REG_SP;
                w_rs2 = w_op[0] ? w_ry : w_rx;
                w_imm = w_op[0] ? w_im5 : w_im8;
                w_aluSrc = 1'b1; w_memWrite = 1'b1; w_aluOp = ALU_ADD;
            end
            5'b11100: begin // ADDU / SUBU
                if (bus.if_instr[0] == 1'b0) begin
                    w_illegal = 1'b1;
                end else begin
                    w_rd = w_rz; w_rs1 = w_rx; w_rs2 = w_ry; w_regWrite = 1'b1;
                    w_aluOp = bus.if_instr[1] ? ALU_SUB : ALU_ADD;
                end
            end
            5'b11101: begin
                case (bus.if_instr[4:0])
                    5'b00000: begin
                        case (bus.if_instr[7:5])
                            3'b000: begin // JR
                                w_rs1 = w_rx; w_jump = 1'b1;
                            end
                            3'b001: begin // JRRA
                                w_rs1 = REG_RA; w_jump = 1'b1;
                            end
                            3'b010: begin // MFPC; the PC value itself travels on ex_pc
                                w_rd = w_rx; w_rs1 = REG_PC;
                                w_regWrite = 1'b1; w_aluOp = ALU_PASSA;
                            end
                            3'b110: begin // JALR; EX writes the return address to RA
                                w_rd = REG_RA; w_rs1 = w_rx;
                                w_regWrite = 1'b1; w_jump = 1'b1;
                            end
                            default: w_illegal = 1'b1;
                        endcase
                    end
                    5'b01100, 5'b01101, 5'b01110: begin // AND / OR / XOR
                        w_rd = w_rx; w_rs1 = w_rx; w_rs2 = w_ry; w_regWrite = 1'b1;
                        w_aluOp = (bus.if_instr[1:0] == 2'b00) ? ALU_AND
                                : (bus.if_instr[1:0] == 2'b01) ? ALU_OR : ALU_XOR;
                    end
                    5'b01111, 5'b01011: begin // NOT / NEG
                        w_rd = w_rx; w_rs1 = w_ry; w_regWrite = 1'b1;
                        w_aluOp = bus.if_instr[2] ? ALU_NOT : ALU_NEG;
                    end
                    5'b01010, 5'b00010, 5'b00011: begin // CMP / SLT / SLTU
                        w_rd = REG_T; w_rs1 = w_rx; w_rs2 = w_ry; w_regWrite = 1'b1;
                        w_aluOp = bus.if_instr[3] ? ALU_CMP
                                : bus.if_instr[0] ? ALU_SLTU : ALU_SLT;
                    end
                    5'b00100, 5'b00110, 5'b00111: begin // SLLV / SRLV / SRAV
                        w_rd = w_ry; w_rs1 = w_ry; w_rs2 = w_rx; w_regWrite = 1'b1;
                        w_aluOp = (bus.if_instr[1:0] == 2'b00) ? ALU_SLL
                                : (bus.if_instr[1:0] == 2'b10) ? ALU_SRL : ALU_SRA;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            5'b11110: begin // MFIH / MTIH
                if (bus.if_instr[7:0] == 8'd0) begin
                    w_rd = w_rx; w_rs1 = REG_IH; w_regWrite = 1'b1; w_aluOp = ALU_PASSA;
                end else if (bus.if_instr[7:0] == 8'd1) begin
                    w_rd = REG_IH; w_rs1 = w_rx; w_regWrite = 1'b1; w_aluOp = ALU_PASSA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Output and load-tracking registers
    logic              r_exValid, r_aluSrc, r_memToReg, r_regWrite, r_memWrite, r_memRead, r_jump;
    logic [1:0]        r_branch;
    logic [3:0]        r_aluOp;
    logic [REG_AW-1:0] r_rd, r_rs1, r_rs2, r_luRd;
    logic [DATA_W-1:0] r_imm, r_pc;
    logic              r_illegal;
    logic [1:0]        r_bubCnt;

    logic w_hazard, w_ifReady, w_transfer;

    // r_luRd can never be REG0 while r_bubCnt is non-zero. An unused source
    // index of REG0 therefore cannot match.
    assign w_hazard   = (r_bubCnt != 2'd0) && bus.if_valid
                     && ((w_rs1 == r_luRd) || (w_rs2 == r_luRd));
    assign w_ifReady  = !rst && !bus.flush && !w_hazard && (!r_exValid || bus.ex_ready);
    assign w_transfer = bus.if_valid && w_ifReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid  <= 1'b0;
            r_aluSrc   <= 1'b0;
            r_memToReg <= 1'b0;
            r_regWrite <= 1'b0;
            r_memWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_jump     <= 1'b0;
            r_branch   <= BR_NB;
            r_aluOp    <= ALU_NO;
            r_rd       <= REG0;
            r_rs1      <= REG0;
            r_rs2      <= REG0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_illegal  <= 1'b0;
            r_bubCnt   <= 2'd0;
            r_luRd     <= REG0;
        end else if (bus.flush) begin
            r_exValid <= 1'b0;
            r_bubCnt  <= 2'd0;
        end else begin
            if (w_transfer) begin
                r_exValid  <= 1'b1;
                r_aluSrc   <= w_aluSrc;
                r_memToReg <= w_memToReg;
                r_regWrite <= w_regWrite;
                r_memWrite <= w_memWrite;
                r_memRead  <= w_memRead;
                r_jump     <= w_jump;
                r_branch   <= w_branch;
                r_aluOp    <= w_aluOp;
                r_rd       <= w_rd;
                r_rs1      <= w_rs1;
                r_rs2      <= w_rs2;
                r_imm      <= w_imm;
                r_pc       <= bus.if_pc;
                r_illegal  <= w_illegal;
            end else if (bus.ex_ready) begin
                r_exValid <= 1'b0;
            end
            // A new load restarts the count. Otherwise the count drains
            // whenever the EX slot is empty or moving.
            if (w_transfer && w_memRead && (w_rd != REG0)) begin
                r_bubCnt <= 2'(LU_BUBBLES);
                r_luRd   <= w_rd;
            end else if ((!r_exValid || bus.ex_ready) && (r_bubCnt != 2'd0)) begin
                r_bubCnt <= r_bubCnt - 2'd1;
            end
        end
    end

    assign bus.if_ready      = w_ifReady;
    assign bus.ex_valid      = r_exValid;
    assign bus.ex_alu_src    = r_aluSrc;
    assign bus.ex_mem_to_reg = r_memToReg;
    assign bus.ex_reg_write  = r_regWrite;
    assign bus.ex_mem_write  = r_memWrite;
    assign bus.ex_mem_read   = r_memRead;
    assign bus.ex_jump       = r_jump;
    assign bus.ex_branch     = r_branch;
    assign bus.ex_alu_op     = r_aluOp;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_rs1        = r_rs1;
    assign bus.ex_rs2        = r_rs2;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_illegal    = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Purpose : Directed bench for decode_stage with LU_BUBBLES = 1. Inputs
//           change 1 time unit after a rising edge. Registered outputs are
//           compared at that same point. The combinational if_ready is
//           compared 1 time unit after the new inputs are applied.
// Ports   : none (top-level bench)
// ---------------------------------------------------------------------------
module tb_decode_stage;
    localparam logic [1:0] BR_NB = 2'd0, BR_B = 2'd1, BR_BE = 2'd2;
    localparam logic [3:0] ALU_NO = 4'd0, ALU_ADD = 4'd1, ALU_SLL = 4'd7,
                           ALU_PASSA = 4'd14, ALU_PASSB = 4'd15;
    localparam logic [3:0] R1 = 4'd1, R2 = 4'd2, R3 = 4'd3, R4 = 4'd4, R5 = 4'd5,
                           R6 = 4'd6, R7 = 4'd7, RPC = 4'd12, REG0 = 4'd15;
    // Control bit order: alu_src, mem_to_reg, reg_write, mem_write, mem_read, jump
    localparam logic [5:0] C_NONE = 6'b000000, C_ALUI = 6'b101000, C_RW = 6'b001000,
                           C_LOAD = 6'b111010, C_STORE = 6'b100100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(16), .REG_AW(4)) dsIf ();

    decode_stage #(.DATA_W(16), .REG_AW(4), .LU_BUBBLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dsIf)
    );

    function automatic logic [63:0] expEx(input logic v, input logic [5:0] ctrl,
                                          input logic [1:0] br, input logic [3:0] op,
                                          input logic [3:0] rd, input logic [3:0] rs1,
                                          input logic [3:0] rs2, input logic [15:0] imm,
                                          input logic [15:0] pc, input logic ill);
        return {6'd0, v, ctrl, br, op, rd, rs1, rs2, imm, pc, ill};
    endfunction

    function automatic logic [63:0] obsEx();
        return {6'd0, dsIf.ex_valid, dsIf.ex_alu_src, dsIf.ex_mem_to_reg, dsIf.ex_reg_write,
                dsIf.ex_mem_write, dsIf.ex_mem_read, dsIf.ex_jump, dsIf.ex_branch,
                dsIf.ex_alu_op, dsIf.ex_rd, dsIf.ex_rs1, dsIf.ex_rs2, dsIf.ex_imm,
                dsIf.ex_pc, dsIf.ex_illegal};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] instr,
                                 input logic [15:0] pc, input logic fl, input logic rdy);
        dsIf.if_valid = v;
        dsIf.if_instr = instr;
        dsIf.if_pc    = pc;
        dsIf.flush    = fl;
        dsIf.ex_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] addiuVec;
        logic [63:0] resetVec;
        resetVec = expEx(1'b0, C_NONE, BR_NB, ALU_NO, REG0, REG0, REG0, 16'h0, 16'h0, 1'b0);

        // Reset with an instruction offered
        applyStimulus(1'b1, 16'h4905, 16'h0100, 1'b0, 1'b1);
        checkOutput("if_ready_in_reset", 64'(dsIf.if_ready), 64'd0);
        tick();
        tick();
        checkOutput("reset_outputs", obsEx(), resetVec);
        checkOutput("reset_bubcnt", 64'(dut.r_bubCnt), 64'd0);

        // ADDIU R1,5
        rst = 1'b0;
        applyStimulus(1'b1, 16'h4905, 16'h0100, 1'b0, 1'b1);
        checkOutput("if_ready_idle", 64'(dsIf.if_ready), 64'd1);
        tick();
        checkOutput("addiu", obsEx(),
                    expEx(1'b1, C_ALUI, BR_NB, ALU_ADD, R1, R1, REG0, 16'h0005, 16'h0100, 1'b0));

        // LW R2->R2,1 followed by a dependent ADDU
        applyStimulus(1'b1, 16'h9A41, 16'h0101, 1'b0, 1'b1);
        tick();
        checkOutput("lw", obsEx(),
                    expEx(1'b1, C_LOAD, BR_NB, ALU_ADD, R2, R2, REG0, 16'h0001, 16'h0101, 1'b0));
        checkOutput("lw_bubcnt", 64'(dut.r_bubCnt), 64'd1);
        applyStimulus(1'b1, 16'hE271, 16'h0102, 1'b0, 1'b1);
        checkOutput("hazard_stall", 64'(dsIf.if_ready), 64'd0);
        tick();
        checkOutput("bubble_valid", 64'(dsIf.ex_valid), 64'd0);
        checkOutput("bubble_bubcnt", 64'(dut.r_bubCnt), 64'd0);
        applyStimulus(1'b1, 16'hE271, 16'h0102, 1'b0, 1'b1);
        checkOutput("hazard_release", 64'(dsIf.if_ready), 64'd1);
        tick();
        checkOutput("addu", obsEx(),
                    expEx(1'b1, C_RW, BR_NB, ALU_ADD, R4, R2, R3, 16'h0000, 16'h0102, 1'b0));

        // LW followed by an independent ADDIU: no stall
        applyStimulus(1'b1, 16'h9A41, 16'h0103, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h4905, 16'h0104, 1'b0, 1'b1);
        checkOutput("indep_ready", 64'(dsIf.if_ready), 64'd1);
        tick();
        addiuVec = expEx(1'b1, C_ALUI, BR_NB, ALU_ADD, R1, R1, REG0, 16'h0005, 16'h0104, 1'b0);
        checkOutput("indep_addiu", obsEx(), addiuVec);
        checkOutput("indep_bubcnt", 64'(dut.r_bubCnt), 64'd0);

        // Hold for 3 cycles while SLL R3,R4,8 (field 0) waits
        applyStimulus(1'b1, 16'h3380, 16'h0105, 1'b0, 1'b0);
        checkOutput("hold_ready", 64'(dsIf.if_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_stable", obsEx(), addiuVec);
        end
        applyStimulus(1'b1, 16'h3380, 16'h0105, 1'b0, 1'b1);
        checkOutput("hold_release", 64'(dsIf.if_ready), 64'd1);
        tick();
        checkOutput("sll_im3_zero", obsEx(),
                    expEx(1'b1, C_ALUI, BR_NB, ALU_SLL, R3, R4, REG0, 16'h0008, 16'h0105, 1'b0));

        // Assorted encodings, back-to-back
        applyStimulus(1'b1, 16'hDBBF, 16'h0106, 1'b0, 1'b1);
        tick();
        checkOutput("sw_im5", obsEx(),
                    expEx(1'b1, C_STORE, BR_NB, ALU_ADD, REG0, R3, R5, 16'hFFFF, 16'h0106, 1'b0));
        applyStimulus(1'b1, 16'h26FE, 16'h0107, 1'b0, 1'b1);
        tick();
        checkOutput("beqz", obsEx(),
                    expEx(1'b1, C_NONE, BR_BE, ALU_NO, REG0, R6, REG0, 16'hFFFE, 16'h0107, 1'b0));
        applyStimulus(1'b1, 16'h6FFF, 16'h0108, 1'b0, 1'b1);
        tick();
        checkOutput("li_zero8", obsEx(),
                    expEx(1'b1, C_ALUI, BR_NB, ALU_PASSB, R7, REG0, REG0, 16'h00FF, 16'h0108, 1'b0));
        applyStimulus(1'b1, 16'hED40, 16'h0109, 1'b0, 1'b1);
        tick();
        checkOutput("mfpc", obsEx(),
                    expEx(1'b1, C_RW, BR_NB, ALU_PASSA, R5, RPC, REG0, 16'h0000, 16'h0109, 1'b0));
        applyStimulus(1'b1, 16'h1400, 16'h010A, 1'b0, 1'b1);
        tick();
        checkOutput("b_im11", obsEx(),
                    expEx(1'b1, C_NONE, BR_B, ALU_NO, REG0, REG0, REG0, 16'hFC00, 16'h010A, 1'b0));

        // Flush while a load is held and an ADDIU is offered, with ex_ready low
        applyStimulus(1'b1, 16'h9A41, 16'h0110, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h4905, 16'h0111, 1'b0, 1'b0);
        tick();
        checkOutput("held_bubcnt", 64'(dut.r_bubCnt), 64'd1);
        applyStimulus(1'b1, 16'h4905, 16'h0111, 1'b1, 1'b0);
        checkOutput("flush_ready", 64'(dsIf.if_ready), 64'd0);
        tick();
        checkOutput("flush_valid", 64'(dsIf.ex_valid), 64'd0);
        checkOutput("flush_bubcnt", 64'(dut.r_bubCnt), 64'd0);
        applyStimulus(1'b1, 16'h4905, 16'h0200, 1'b0, 1'b1);
        tick();
        checkOutput("post_flush_addiu", obsEx(),
                    expEx(1'b1, C_ALUI, BR_NB, ALU_ADD, R1, R1, REG0, 16'h0005, 16'h0200, 1'b0));

        // Illegal opcode, then reset during a load-use stall
        applyStimulus(1'b1, 16'hF800, 16'h0300, 1'b0, 1'b1);
        tick();
        checkOutput("illegal", obsEx(),
                    expEx(1'b1, C_NONE, BR_NB, ALU_NO, REG0, REG0, REG0, 16'h0000, 16'h0300, 1'b1));
        applyStimulus(1'b1, 16'h9A41, 16'h0301, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'hE271, 16'h0302, 1'b0, 1'b1);
        checkOutput("stall_before_reset", 64'(dsIf.if_ready), 64'd0);
        rst = 1'b1;
        tick();
        checkOutput("mid_stall_reset", obsEx(), resetVec);
        checkOutput("mid_stall_bubcnt", 64'(dut.r_bubCnt), 64'd0);
        checkOutput("mid_stall_lurd", 64'(dut.r_luRd), 64'(REG0));
        rst = 1'b0;
        applyStimulus(1'b1, 16'hE271, 16'h0302, 1'b0, 1'b1);
        checkOutput("ready_after_reset", 64'(dsIf.if_ready), 64'd1);
        tick();
        checkOutput("addu_after_reset", obsEx(),
                    expEx(1'b1, C_RW, BR_NB, ALU_ADD, R4, R2, R3, 16'h0000, 16'h0302, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
